// File: rtl/qrow_fetch.sv
// qrow_fetch: reads the four action Q-values of one state row from the
// Q-table RAM and presents them together to the max/argmax stage.
// Handshake in: req_valid/req_ready. Handshake out: out_valid/out_ready.
module qrow_fetch #(
    parameter int DATA_LENGTH = 32,
    parameter int STATE_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [STATE_WIDTH-1:0]   req_state,
    output logic                     mem_rd_en,
    output logic [STATE_WIDTH+1:0]   mem_addr,
    input  logic [DATA_LENGTH-1:0]   mem_rdata,
    output logic [DATA_LENGTH-1:0]   qvalue_0,
    output logic [DATA_LENGTH-1:0]   qvalue_1,
    output logic [DATA_LENGTH-1:0]   qvalue_2,
    output logic [DATA_LENGTH-1:0]   qvalue_3,
    output logic                     out_valid,
    input  logic                     out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LAST = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                   state_reg, state_next;
    logic [1:0]               cnt_reg, cnt_next;
    logic [STATE_WIDTH-1:0]   row_reg, row_next;
    logic                     rd_d_reg;
    logic [1:0]               cnt_d_reg;
    logic [DATA_LENGTH-1:0]   q_reg [4];

    // FSM, action counter and latched row index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            row_reg   <= row_next;
        end
    end

    // Next-state logic; a row is only captured on acceptance so later
    // req_state changes cannot disturb a fetch in flight
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        row_next   = row_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    row_next   = req_state;
                    cnt_next   = 2'd0;
                    state_next = READ;
                end
            end
            READ: begin
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == 2'd3) begin
                    state_next = LAST;
                end
            end
            LAST: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read strobe and address; the address concatenation never carries
    // into the state bits, so the all-ones row stays at the top of memory
    always_comb begin
        mem_rd_en = (state_reg == READ);
        mem_addr  = {row_reg, cnt_reg};
        out_valid = (state_reg == HOLD);
        req_ready = (state_reg == IDLE) && !rst;
    end

    // Delayed strobe/counter: RAM data arrives one cycle after the strobe,
    // so this pair tells which action register the returning word belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d_reg  <= 1'b0;
            cnt_d_reg <= 2'd0;
        end else begin
            rd_d_reg  <= mem_rd_en;
            cnt_d_reg <= cnt_reg;
        end
    end

    // One capture register per action; each loads only its own word
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_qreg
            // Capture read data for action gi, otherwise hold
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg[gi] <= '0;
                end else if (rd_d_reg && (cnt_d_reg == 2'(gi))) begin
                    q_reg[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    assign qvalue_0 = q_reg[0];
    assign qvalue_1 = q_reg[1];
    assign qvalue_2 = q_reg[2];
    assign qvalue_3 = q_reg[3];

endmodule

// File: tb/tb_qrow_fetch.sv
// tb_qrow_fetch: directed and randomized fetches against a behavioural RAM
// and row model; checks timing, data, backpressure, back-to-back and reset.
module tb_qrow_fetch;

    localparam int DW = 32;
    localparam int SW = 8;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [SW-1:0]   req_state;
    logic            mem_rd_en;
    logic [SW+1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata;
    logic [DW-1:0]   qvalue_0, qvalue_1, qvalue_2, qvalue_3;
    logic            out_valid;
    logic            out_ready;

    qrow_fetch #(.DATA_LENGTH(DW), .STATE_WIDTH(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_state (req_state),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .qvalue_0  (qvalue_0),
        .qvalue_1  (qvalue_1),
        .qvalue_2  (qvalue_2),
        .qvalue_3  (qvalue_3),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural Q-table RAM with one-cycle registered read
    logic [DW-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    // Event monitor: cycle counter, acceptances, read addresses, valid sightings
    int        cyc = 0;
    int        acc_cyc_q[$];
    int        acc_state_q[$];
    int        addr_q[$];
    int        valid_seen = 0;
    always @(posedge clk) begin
        if (req_valid && req_ready) begin
            acc_cyc_q.push_back(cyc);
            acc_state_q.push_back(int'(req_state));
        end
        if (mem_rd_en) addr_q.push_back(int'(mem_addr));
        if (out_valid) valid_seen <= valid_seen + 1;
        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] model_q(input int s, input int k);
        return ram[s * 4 + k];
    endfunction

    task automatic check_row(input string tag, input int s);
        check({tag, "_q0"}, 64'(qvalue_0), 64'(model_q(s, 0)));
        check({tag, "_q1"}, 64'(qvalue_1), 64'(model_q(s, 1)));
        check({tag, "_q2"}, 64'(qvalue_2), 64'(model_q(s, 2)));
        check({tag, "_q3"}, 64'(qvalue_3), 64'(model_q(s, 3)));
    endtask

    // One complete fetch of row s, holding out_ready low for hold cycles in HOLD
    task automatic fetch(input int s, input int hold);
        @(negedge clk);
        req_valid = 1'b1;
        req_state = SW'(s);
        out_ready = 1'($urandom);
        check("idle_ready", 64'(req_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'($urandom);
            req_state = SW'($urandom);
            out_ready = 1'($urandom);
            check("read_en", 64'(mem_rd_en), 64'd1);
            check("read_addr", 64'(mem_addr), 64'(s * 4 + k));
            check("read_ready", 64'(req_ready), 64'd0);
            check("read_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("last_en", 64'(mem_rd_en), 64'd0);
        check("last_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        out_ready = (hold == 0);
        check("hold_out_valid", 64'(out_valid), 64'd1);
        check_row("hold", s);
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_en", 64'(mem_rd_en), 64'd0);
            check_row("bp", s);
            if (h == hold) out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("done_out_valid", 64'(out_valid), 64'd0);
        check("done_ready", 64'(req_ready), 64'd1);
        check_row("done", s);
        $display("fetch state=%0d hold=%0d q=%0h %0h %0h %0h", s, hold,
                 qvalue_0, qvalue_1, qvalue_2, qvalue_3);
    endtask

    initial begin
        int arg;
        logic signed [DW-1:0] best;
        logic signed [DW-1:0] qs [4];
        int base;
        int s;

        for (int a = 0; a < 1024; a++) ram[a] = DW'(a * 3 - 100);
        rst = 1'b1;
        req_valid = 1'b0;
        req_state = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_en", 64'(mem_rd_en), 64'd0);
        check("rst_q0", 64'(qvalue_0), 64'd0);
        check("rst_q3", 64'(qvalue_3), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'd1);

        // Known preload: row 5 -> -40, -37, -34, -31
        fetch(5, 0);
        check("row5_q0", 64'(qvalue_0), 64'(32'hFFFF_FFD8));
        check("row5_q3", 64'(qvalue_3), 64'(32'hFFFF_FFE1));

        // Extreme data, argmax of the returned row must be action 1
        ram[160] = 32'h8000_0000;
        ram[161] = 32'h7FFF_FFFF;
        ram[162] = 32'h0000_0000;
        ram[163] = 32'hFFFF_FFFF;
        fetch(40, 0);
        qs[0] = qvalue_0; qs[1] = qvalue_1; qs[2] = qvalue_2; qs[3] = qvalue_3;
        arg = 0;
        best = qs[0];
        for (int k = 1; k < 4; k++) if (qs[k] > best) begin best = qs[k]; arg = k; end
        check("argmax", 64'(arg), 64'd1);

        // Backpressure for 10 cycles
        fetch(77, 10);

        // Top row, no wrap
        fetch(255, 2);

        // Randomized rows, data and backpressure
        for (int t = 0; t < 12; t++) begin
            s = int'($urandom_range(0, 255));
            for (int k = 0; k < 4; k++) ram[s * 4 + k] = $urandom;
            fetch(s, int'($urandom_range(0, 3)));
        end

        // Back-to-back with req_valid held high: states 7 then 255
        @(negedge clk);
        out_ready = 1'b1;
        acc_cyc_q.delete();
        acc_state_q.delete();
        addr_q.delete();
        req_valid = 1'b1;
        req_state = 8'd7;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (acc_cyc_q.size() == 1) req_state = 8'd255;
            if (acc_cyc_q.size() >= 2) req_valid = 1'b0;
        end
        check("b2b_accepts", 64'(acc_cyc_q.size()), 64'd2);
        if (acc_cyc_q.size() >= 2) begin
            check("b2b_spacing", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd7);
            check("b2b_state0", 64'(acc_state_q[0]), 64'd7);
            check("b2b_state1", 64'(acc_state_q[1]), 64'd255);
        end
        check("b2b_nreads", 64'(addr_q.size()), 64'd8);
        if (addr_q.size() >= 8) begin
            for (int k = 0; k < 4; k++) begin
                check("b2b_addr7", 64'(addr_q[k]), 64'(28 + k));
                check("b2b_addr255", 64'(addr_q[4 + k]), 64'(1020 + k));
            end
        end
        check_row("b2b", 255);
        $display("b2b accepts=%0d reads=%0d", acc_cyc_q.size(), addr_q.size());
        out_ready = 1'b0;

        // Reset at cycle 3 of a fetch aborts it; no valid for the partial row
        ram[36] = 32'hDEAD_0001;
        ram[37] = 32'hDEAD_0002;
        ram[38] = 32'hDEAD_0003;
        ram[39] = 32'hDEAD_0004;
        @(negedge clk);
        req_valid = 1'b1;
        req_state = 8'd9;
        out_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        base = valid_seen;
        #2 rst = 1'b1;
        #1;
        check("abort_en", 64'(mem_rd_en), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_q", 64'({qvalue_0, qvalue_1} | {qvalue_2, qvalue_3}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        check("abort_post_ready", 64'(req_ready), 64'd1);
        repeat (10) @(negedge clk);
        check("abort_no_valid", 64'(valid_seen - base), 64'd0);
        check("abort_q0_clear", 64'(qvalue_0), 64'd0);
        $display("reset abort valid_sightings=%0d", valid_seen - base);
        fetch(9, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/qrow_fetch.md
QROW_FETCH -- requirements
Module: qrow_fetch

Interface
REQ-001 Parameter DATA_LENGTH, default 32: width of one Q-value word (signed, two's complement).
REQ-002 Parameter STATE_WIDTH, default 8: width of state index; Q-table holds 2^STATE_WIDTH rows of 4 actions.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  fetch request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_state  in  STATE_WIDTH  state index of row to fetch; sampled on acceptance.
REQ-008 mem_rd_en  out  1  Q-table RAM read strobe.
REQ-009 mem_addr  out  STATE_WIDTH+2  RAM word address = {state, action[1:0]}.
REQ-010 mem_rdata  in  DATA_LENGTH  RAM read data, valid exactly 1 cycle after the cycle mem_rd_en is high.
REQ-011 qvalue_0..qvalue_3  out  DATA_LENGTH each  Q-values of actions 0..3, feeding the 4-way max/argmax stage.
REQ-012 out_valid  out  1  qvalue_0..3 hold a complete row.
REQ-013 out_ready  in  1  downstream consumes the row.

Function
REQ-014 FSM states SHALL be IDLE, READ, LAST, HOLD.
REQ-015 req_ready SHALL be 1 only in IDLE; acceptance = req_valid & req_ready at a rising edge.
REQ-016 On acceptance: latch req_state, clear 2-bit action counter, go to READ.
REQ-017 In READ: mem_rd_en=1, mem_addr={latched state, counter}; counter increments each cycle; after counter=3 go to LAST.
REQ-018 mem_rd_en SHALL be 0 in IDLE, LAST, HOLD; mem_addr value irrelevant when mem_rd_en=0 but SHALL be driven (no X).
REQ-019 A 1-cycle-delayed copy of mem_rd_en and counter SHALL select which qvalue_k register captures mem_rdata at the next edge.
REQ-020 LAST lasts exactly 1 cycle, captures action-3 data, then goes to HOLD.
REQ-021 Timing: acceptance edge ends cycle 0; mem_rd_en high in cycles 1-4 (addresses a+0..a+3); out_valid high from cycle 6.
REQ-022 In HOLD: out_valid=1; qvalue_0..3 SHALL stay stable until out_valid & out_ready at an edge, then go to IDLE.
REQ-023 out_valid SHALL be 0 in all states except HOLD; out_ready SHALL be ignored outside HOLD.
REQ-024 Minimum request-to-request spacing: 7 cycles with out_ready tied high (IDLE->READ x4->LAST->HOLD->IDLE).
REQ-025 req_valid while busy SHALL be ignored; req_state changes after acceptance SHALL not affect the fetch.
REQ-026 qvalue_k registers SHALL change only when capturing their own action's read data; otherwise hold last value.
REQ-027 Data SHALL pass bit-exact, no sign extension, truncation or arithmetic.
REQ-028 State index all-ones SHALL address words 2^(STATE_WIDTH+2)-4 .. 2^(STATE_WIDTH+2)-1 without wrap to 0.

Reset
REQ-029 While rst=1: state=IDLE, counter=0, delayed strobe=0, qvalue_0..3=0, out_valid=0, mem_rd_en=0, req_ready=0.
REQ-030 rst asserted mid-fetch SHALL abort immediately (asynchronously); no partial row SHALL ever be flagged valid.
REQ-031 First edge after rst deasserts: req_ready=1 (IDLE), request acceptable on that edge.

Verification
REQ-032 RAM preloaded word(addr)=addr*3-100; request state 5 -> mem_addr 20,21,22,23 in cycles 1-4; out_valid cycle 6; qvalues -40,-37,-34,-31.
REQ-033 Negative/extreme data: row {32'h8000_0000, 32'h7FFF_FFFF, 0, -1} -> outputs bit-exact; downstream max stage reports arg=1.
REQ-034 Backpressure: out_ready low 10 cycles in HOLD -> out_valid and qvalues stable, req_ready 0, mem_rd_en 0; release -> IDLE next cycle.
REQ-035 Back-to-back: req_valid held high with states 7 then 255, out_ready=1 -> second acceptance exactly 7 cycles after first; addresses 1020-1023 for state 255.
REQ-036 Reset at cycle 3 of a fetch -> all outputs 0 during reset, out_valid never asserts for the aborted row; new request afterwards completes normally.
